// File: rtl/sc_random_pkg.sv
// Shared definitions for the shared random-number arbiter: FSM encoding,
// LFSR geometry (x^4+x^3+1) and seeding constants.
package sc_random_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_A  = 3;
  localparam int TAP_B  = 2;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b0001;
  // An all-zero LFSR never leaves zero, so a zero seed is replaced by this.
  localparam logic [LFSR_W-1:0] LOCKUP_SEED  = 4'b0001;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_STEP_ENC    = 2'd1;
  localparam logic [1:0] ST_DELIVER_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_STEP    = ST_STEP_ENC,
    ST_DELIVER = ST_DELIVER_ENC
  } state_t;

  // One Fibonacci shift: new LSB is the XOR of the two tap bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], l[TAP_A] ^ l[TAP_B]};
  endfunction

endpackage

// File: rtl/sc_lfsr4_step.sv
// 4-bit LFSR register: steps when enabled, synchronous seed load with
// zero-seed guard. o_nxt exposes the post-step value for capture elsewhere.
module sc_lfsr4_step
  import sc_random_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_q,
  output logic [LFSR_W-1:0] o_nxt
);

  logic [LFSR_W-1:0] r_q;

  assign o_nxt = lfsr_next(r_q);
  assign o_q   = r_q;

  // Load has priority over stepping; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= SEED;
    else if (i_load) r_q <= (i_seed == '0) ? LOCKUP_SEED : i_seed;
    else if (i_en)   r_q <= o_nxt;
  end

endmodule

// File: rtl/sc_random_arbiter.sv
// Round-robin arbiter handing out values from one shared LFSR. Each
// delivery advances the LFSR SKIP times; the LFSR only moves while a
// request is being served, and seeding is only accepted while idle.
module sc_random_arbiter
  import sc_random_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter int                SKIP    = 2,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic               SC_RandARB_CLOCK_50,
  input  logic               SC_RandARB_RESET_InLow,
  input  logic [NUM_REQ-1:0] SC_RandARB_req_InBUS,
  input  logic [LFSR_W-1:0]  SC_RandARB_seed_InBUS,
  input  logic               SC_RandARB_seed_Load,
  output logic [NUM_REQ-1:0] SC_RandARB_grant_OutBUS,
  output logic               SC_RandARB_valid_Out,
  output logic [LFSR_W-1:0]  SC_RandARB_data_OutBUS,
  output logic               SC_RandARB_busy_Out
);

  localparam int             PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]  LAST     = PW'(NUM_REQ - 1);
  localparam logic [PW:0]    NREQ_EXT = (PW+1)'(NUM_REQ);
  localparam logic [3:0]     CNT_LAST = 4'(SKIP - 1);

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_ptr, r_win, w_pick, w_ptr_inc;
  logic [3:0]          r_cnt;
  logic                w_any, w_win_req, w_lfsr_en, w_lfsr_ld, w_start, w_deliver;
  logic [LFSR_W-1:0]   w_lfsr_q, w_lfsr_nxt;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_valid, r_busy;
  logic [LFSR_W-1:0]   r_data;

  sc_lfsr4_step #(.SEED(SEED)) u_lfsr (
    .clk    (SC_RandARB_CLOCK_50),
    .rst_n  (SC_RandARB_RESET_InLow),
    .i_en   (w_lfsr_en),
    .i_load (w_lfsr_ld),
    .i_seed (SC_RandARB_seed_InBUS),
    .o_q    (w_lfsr_q),
    .o_nxt  (w_lfsr_nxt)
  );

  // Round-robin search: first set request at or above r_ptr, wrapping.
  always_comb begin
    logic [PW:0] w_sum;
    w_sum  = '0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= NREQ_EXT) w_sum = w_sum - NREQ_EXT;
      if (!w_any && SC_RandARB_req_InBUS[w_sum[PW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[PW-1:0];
      end
    end
  end

  assign w_win_req = SC_RandARB_req_InBUS[r_win];
  assign w_ptr_inc = (r_win == LAST) ? '0 : r_win + 1'b1;

  // Next-state logic. The abort check wins over delivery, and the LFSR
  // steps on every STEP edge, including an aborting one.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_en   = 1'b0;
    w_lfsr_ld   = 1'b0;
    w_start     = 1'b0;
    w_deliver   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (SC_RandARB_seed_Load) begin
          w_lfsr_ld = 1'b1;             // seed first; a pending request waits
        end else if (w_any) begin
          w_start     = 1'b1;
          w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        w_lfsr_en = 1'b1;
        if (!w_win_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_deliver   = 1'b1;
          w_state_nxt = ST_DELIVER;
        end
      end
      ST_DELIVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // State, winner/pointer bookkeeping and registered outputs.
  always_ff @(posedge SC_RandARB_CLOCK_50 or negedge SC_RandARB_RESET_InLow) begin
    if (!SC_RandARB_RESET_InLow) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_valid <= w_deliver;
      r_grant <= w_deliver ? (NUM_REQ'(1) << r_win) : '0;
      if (w_start) begin
        r_win <= w_pick;
        r_cnt <= '0;
      end else if (r_state == ST_STEP) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_deliver)              r_data <= w_lfsr_nxt;
      if (r_state == ST_DELIVER)  r_ptr  <= w_ptr_inc;
    end
  end

  assign SC_RandARB_grant_OutBUS = r_grant;
  assign SC_RandARB_valid_Out    = r_valid;
  assign SC_RandARB_data_OutBUS  = r_data;
  assign SC_RandARB_busy_Out     = r_busy;

endmodule
